// File: rtl/div_arbiter.sv
// Round-robin front end sharing one iterative divider; div-by-zero answers at T+1 without the divider.
// One request in flight; the response is held until the granted lane accepts. Watchdog: DIV_ARB_TIMEOUT_EN.
module div_arbiter #(
    parameter int D_W         = 32,
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*D_W-1:0] req_divisor,
    input  logic [N_REQ*D_W-1:0] req_dividend,
    output logic [N_REQ-1:0]     resp_valid,
    input  logic [N_REQ-1:0]     resp_ready,
    output logic [D_W-1:0]       resp_quotient,
    output logic                 resp_dz,
    output logic                 resp_err,
    output logic                 div_in_valid,
    output logic [D_W-1:0]       div_divisor,
    output logic [D_W-1:0]       div_divident,
    input  logic [D_W-1:0]       div_quotient,
    input  logic                 div_out_valid,
    output logic                 div_rst
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    if (N_REQ < 2) begin : g_bad_nreq
        $error("div_arbiter: N_REQ must be at least 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("div_arbiter: TIMEOUT_CYC must be at least 1");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [D_W-1:0]   dvs_q, dvs_d;
    logic [D_W-1:0]   dvd_q, dvd_d;
    logic [D_W-1:0]   quot_q, quot_d;
    logic             dz_q, dz_d;
    logic             timeout_hit;

    logic             gnt_found;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W:0]   gnt_sum;
    logic [D_W-1:0]   sel_dvs, sel_dvd;

    // First requesting lane at or after the rr pointer, wrapping at N_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            gnt_sum = {1'b0, rr_q} + (IDX_W+1)'(k);
            if (gnt_sum >= (IDX_W+1)'(N_REQ)) begin
                gnt_sum = gnt_sum - (IDX_W+1)'(N_REQ);
            end
            if (!gnt_found && req_valid[gnt_sum[IDX_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = gnt_sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        sel_dvs = '0;
        sel_dvd = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (IDX_W'(k) == gnt_idx) begin
                sel_dvs = req_divisor[k*D_W +: D_W];
                sel_dvd = req_dividend[k*D_W +: D_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        grant_d      = grant_q;
        dvs_d        = dvs_q;
        dvd_d        = dvd_q;
        quot_d       = quot_q;
        dz_d         = dz_q;
        req_ready    = '0;
        resp_valid   = '0;
        div_in_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    req_ready[gnt_idx] = 1'b1;
                    grant_d            = gnt_idx;
                    dvs_d              = sel_dvs;
                    dvd_d              = sel_dvd;
                    if (sel_dvs == '0) begin
                        quot_d  = '1;
                        dz_d    = 1'b1;
                        state_d = RESP;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                div_in_valid = 1'b1;
                state_d      = WAIT;
            end
            WAIT: begin
                if (div_out_valid) begin
                    quot_d  = div_quotient;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    quot_d  = '1;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid[grant_q] = 1'b1;
                if (resp_ready[grant_q]) begin
                    rr_d    = (grant_q == IDX_W'(N_REQ-1)) ? '0 : grant_q + IDX_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            quot_q  <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            dvs_q   <= dvs_d;
            dvd_q   <= dvd_d;
            quot_q  <= quot_d;
            dz_q    <= dz_d;
        end
    end

    assign div_divisor   = dvs_q;
    assign div_divident  = dvd_q;
    assign resp_quotient = quot_q;
    assign resp_dz       = dz_q;

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wd_q, wd_d;
    logic             err_q, err_d;

    // Counter is zero on every WAIT entry because it is held clear outside WAIT.
    assign timeout_hit = (state_q == WAIT) && !div_out_valid &&
                         (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign cnt_d = (state_q == WAIT) ? cnt_q + CNT_W'(1) : '0;
    assign wd_d  = timeout_hit;
    assign err_d = (state_q == IDLE) ? 1'b0 : (timeout_hit ? 1'b1 : err_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            wd_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign resp_err = err_q;
    assign div_rst  = rst | wd_q;
`else
    assign timeout_hit = 1'b0;
    assign resp_err    = 1'b0;
    assign div_rst     = rst;
`endif

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural iterative divider plus a response scoreboard.
module tb_div_arbiter;

    localparam int N      = 4;
    localparam int DW     = 32;
    localparam int DIV_LAT = 4;
    localparam int TO_CYC = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_divisor;
    logic [N*DW-1:0] req_dividend;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready;
    logic [DW-1:0]   resp_quotient;
    logic            resp_dz;
    logic            resp_err;
    logic            div_in_valid;
    logic [DW-1:0]   div_divisor;
    logic [DW-1:0]   div_divident;
    logic [DW-1:0]   div_quotient = '0;
    logic            div_out_valid = 1'b0;
    logic            div_rst;

    div_arbiter #(.D_W(DW), .N_REQ(N), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_divisor(req_divisor), .req_dividend(req_dividend),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_quotient(resp_quotient), .resp_dz(resp_dz), .resp_err(resp_err),
        .div_in_valid(div_in_valid), .div_divisor(div_divisor), .div_divident(div_divident),
        .div_quotient(div_quotient), .div_out_valid(div_out_valid), .div_rst(div_rst)
    );

    always #5 clk = ~clk;

    // Divider model: answers DIV_LAT cycles after in_valid unless hung.
    logic          hang = 1'b0;
    logic          busy = 1'b0;
    int            dcnt = 0;
    logic [DW-1:0] da = '0, db = '0;

    always @(posedge clk) begin
        div_out_valid <= 1'b0;
        if (div_rst) begin
            busy <= 1'b0;
        end else if (div_in_valid) begin
            busy <= 1'b1;
            da   <= div_divident;
            db   <= div_divisor;
            dcnt <= DIV_LAT;
        end else if (busy && !hang) begin
            if (dcnt == 1) begin
                div_out_valid <= 1'b1;
                div_quotient  <= da / db;
                busy          <= 1'b0;
            end else begin
                dcnt <= dcnt - 1;
            end
        end
    end

    typedef struct {
        int            lane;
        logic [DW-1:0] q;
        logic          dz;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_issue = 0;
    int   n_drst = 0;
    int   t_issue = 0;
    int   t_drst = 0;
    logic          pend_chk = 1'b0;
    int            pend_lane = 0;
    logic [DW-1:0] pend_dvs = '0, pend_dvd = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic req(input int lane, input logic [DW-1:0] dvd, input logic [DW-1:0] dvs);
        req_dividend[lane*DW +: DW] = dvd;
        req_divisor[lane*DW +: DW]  = dvs;
        req_valid[lane]             = 1'b1;
    endtask

    task automatic expect_resp(input int lane, input logic [DW-1:0] q, input logic dz, input logic err);
        exp_t e;
        e.lane = lane; e.q = q; e.dz = dz; e.err = err;
        sb.push_back(e);
    endtask

    // One clock: observe at the falling edge, then retire handshaken requests after the rising edge.
    task automatic tick();
        logic [N-1:0] hs;
        exp_t         e;
        @(negedge clk);
        cyc++;
        hs = req_valid & req_ready;
        if (pend_chk) begin
            if (pend_dvs == '0) begin
                check_eq("dz_resp_t1", resp_valid, 64'(1) << pend_lane);
                check_eq("dz_no_issue", div_in_valid, 0);
            end else begin
                check_eq("issue_t1", div_in_valid, 1);
                check_eq("issue_divisor", div_divisor, pend_dvs);
                check_eq("issue_dividend", div_divident, pend_dvd);
            end
            pend_chk = 1'b0;
        end
        if (req_ready != '0) check_eq("ready_onehot", $onehot(req_ready & req_valid), 1);
        if (hs != '0) begin
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    pend_lane = i;
                    pend_dvs  = req_divisor[i*DW +: DW];
                    pend_dvd  = req_dividend[i*DW +: DW];
                end
            end
            pend_chk = 1'b1;
        end
        if (div_in_valid) begin n_issue++; t_issue = cyc; end
        if (div_rst)      begin n_drst++;  t_drst  = cyc; end
        if ((resp_valid & resp_ready) != '0) begin
            if (sb.size() == 0) begin
                check_eq("resp_unexpected", resp_valid, 0);
            end else begin
                e = sb.pop_front();
                check_eq("resp_lane", resp_valid, 64'(1) << e.lane);
                check_eq("resp_quotient", resp_quotient, e.q);
                check_eq("resp_dz", resp_dz, e.dz);
                check_eq("resp_err", resp_err, e.err);
            end
        end
        @(posedge clk);
        #1;
        req_valid = req_valid & ~hs;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || req_valid != '0 || resp_valid != '0) && n < budget) begin
            tick();
            n++;
        end
        check_eq("drain_empty", sb.size(), 0);
        check_eq("drain_idle", resp_valid, 0);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_resp_valid"}, resp_valid, 0);
        check_eq({tag, "_req_ready"}, req_ready, 0);
        check_eq({tag, "_div_in_valid"}, div_in_valid, 0);
        check_eq({tag, "_div_divisor"}, div_divisor, 0);
        check_eq({tag, "_div_divident"}, div_divident, 0);
        check_eq({tag, "_quotient"}, resp_quotient, 0);
        check_eq({tag, "_dz"}, resp_dz, 0);
        check_eq({tag, "_err"}, resp_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        rst          = 1'b1;
        req_valid    = '0;
        resp_ready   = '1;
        req_divisor  = '0;
        req_dividend = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_div_rst", div_rst, 1);
        check_quiet("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All four lanes at once: strict order 0,1,2,3.
        req(0, 50, 5); req(1, 60, 6); req(2, 70, 7); req(3, 81, 9);
        expect_resp(0, 10, 0, 0);
        expect_resp(1, 10, 0, 0);
        expect_resp(2, 10, 0, 0);
        expect_resp(3, 9, 0, 0);
        drain(200);

        // Pointer has wrapped, so lane 0 wins over lane 3.
        req(3, 9, 3); req(0, 100, 7);
        expect_resp(0, 14, 0, 0);
        expect_resp(3, 3, 0, 0);
        drain(100);

        // Divide by zero: answered at T+1, divider untouched.
        base = n_issue;
        req(2, 1234, 0);
        expect_resp(2, 32'hFFFF_FFFF, 1, 0);
        drain(50);
        check_eq("dz_issue_count", n_issue - base, 0);

        // Held response: lane 1 not ready, lane 0 waits behind it.
        resp_ready = 4'b1101;
        req(1, 3, 8);
        expect_resp(1, 0, 0, 0);
        n = 0;
        while (resp_valid == '0 && n < 50) begin tick(); n++; end
        check_eq("hold_resp_seen", resp_valid, 4'b0010);
        req(0, 77, 11);
        expect_resp(0, 7, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("hold_valid", resp_valid, 4'b0010);
            check_eq("hold_quotient", resp_quotient, 0);
            check_eq("hold_no_grant", req_ready, 0);
            check_eq("hold_lane0_pending", req_valid[0], 1);
        end
        resp_ready = '1;
        drain(100);

        // Reset while waiting on the divider: result discarded.
        req(0, 100, 7);
        base = n_issue;
        n = 0;
        while (n_issue == base && n < 20) begin tick(); n++; end
        check_eq("rst_wait_issued", n_issue - base, 1);
        tick();
        rst = 1'b1;
        #1;
        check_eq("rst_wait_div_rst", div_rst, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pend_chk = 1'b0;
        @(negedge clk);
        check_quiet("rst_wait");
        @(posedge clk);
        #1;
        req(0, 100, 7);
        expect_resp(0, 14, 0, 0);
        drain(100);

`ifdef DIV_ARB_TIMEOUT_EN
        // Hung divider: watchdog pulse TO_CYC cycles after WAIT entry.
        hang = 1'b1;
        base = n_drst;
        req(2, 5, 1);
        expect_resp(2, 32'hFFFF_FFFF, 0, 1);
        drain(100);
        check_eq("wd_pulses", n_drst - base, 1);
        check_eq("wd_delay", t_drst - t_issue, TO_CYC + 1);
        hang = 1'b0;
        req(1, 21, 7);
        expect_resp(1, 3, 0, 0);
        drain(100);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
